// File: rtl/lsu_dmem.sv
// Load/store unit: turns a MEM-stage load/store into a word-aligned dmem request,
// waits out the gnt/rvalid handshake and returns extended load data or an error pulse.
module lsu_dmem #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [2:0]            mem_funct3,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  stall,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  mem_exc,
  output logic                  bus_err,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_wstrb,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  // Handshake: a request is transferred in the cycle where dmem_req && dmem_gnt;
  // dmem_* stay stable until then. Read data is consumed in the cycle dmem_rvalid
  // is high (the grant cycle or later), and only while an access is outstanding.

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_we;
  logic [2:0]      op_f3;
  logic [1:0]      op_off;

  logic                  f3_legal;
  logic                  misaligned;
  logic                  op_bad;
  logic                  accept;
  logic                  busy;
  logic                  done_now;
  logic [3:0]            st_wstrb;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  always_comb begin
    f3_legal = 1'b0;
    case (mem_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !mem_we;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = 1'b0;
    case (mem_funct3[1:0])
      2'b01:   misaligned = mem_addr[0];
      2'b10:   misaligned = |mem_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    op_bad = !f3_legal || misaligned;
    accept = (state == S_IDLE) && mem_valid && !op_bad;
  end

  assign busy    = (state == S_REQ) || (state == S_WAIT);
  assign stall   = accept || busy;
  assign mem_exc = (state == S_IDLE) && mem_valid && op_bad;

  // A load is complete only once its data is in hand; a store once it is granted.
  assign done_now = ((state == S_REQ) && dmem_gnt && (op_we || dmem_rvalid)) ||
                    ((state == S_WAIT) && dmem_rvalid);

  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = '0;
    if (mem_we) begin
      case (mem_funct3[1:0])
        2'b00: begin
          st_wstrb = 4'b0001 << mem_addr[1:0];
          st_wdata = {4{mem_wdata[7:0]}};
        end
        2'b01: begin
          st_wstrb = 4'b0011 << mem_addr[1:0];
          st_wdata = {2{mem_wdata[15:0]}};
        end
        default: begin
          st_wstrb = 4'b1111;
          st_wdata = mem_wdata;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = dmem_rdata[{op_off, 3'b000} +: 8];
    ld_half = dmem_rdata[{op_off[1], 4'b0000} +: 16];
    case (op_f3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'b0, ld_byte};
      3'b101:  ld_ext = {16'b0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_we      <= 1'b0;
      op_f3      <= 3'b000;
      op_off     <= 2'b00;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wstrb <= 4'b0000;
      dmem_wdata <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      bus_err    <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            op_we      <= mem_we;
            op_f3      <= mem_funct3;
            op_off     <= mem_addr[1:0];
            dmem_req   <= 1'b1;
            dmem_we    <= mem_we;
            dmem_addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
            dmem_wstrb <= st_wstrb;
            dmem_wdata <= st_wdata;
            state      <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (done_now) begin
            dmem_req <= 1'b0;
            if (!op_we) begin
              load_data  <= ld_ext;
              load_valid <= 1'b1;
            end
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            // Abort: a timed-out load still retires, with zero data.
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            if (!op_we) begin
              load_data  <= '0;
              load_valid <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
            if ((state == S_REQ) && dmem_gnt) begin
              dmem_req <= 1'b0;
              state    <= S_WAIT;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Randomised bench for lsu_dmem: a driver plays MEM stage and memory, a monitor
// compares every request, load result, error pulse and stall window with a model.
module tb_lsu_dmem;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        mem_exc;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  lsu_dmem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .mem_exc(mem_exc), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [7:0]  len;
  } req_exp_t;

  req_exp_t    req_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exc_q[$];
  logic [31:0] err_q[$];
  logic [7:0]  stall_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model, written from the access rules with plain arithmetic
  function automatic logic op_legal(input logic we, input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b1;
    if (!we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic op_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    int o;
    o = addr % 4;
    b = (rd >> (8 * o)) & 32'd255;
    h = (rd >> (16 * (o / 2))) & 32'd65535;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    int o;
    o = addr % 4;
    if (f3 == 3'd0) return 4'(1 << o);
    if (f3 == 3'd1) return 4'(3 << o);
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return (wd & 32'd255) * 32'h0101_0101;
    if (f3 == 3'd1) return (wd & 32'd65535) * 32'h0001_0001;
    return wd;
  endfunction

  // driver tasks: each starts and ends 1 time unit after a rising edge with the DUT idle
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int gdly, input int rdly,
                       input logic [31:0] rd);
    int t_done, last;
    logic complete;
    req_exp_t e;
    mem_valid = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (!op_legal(we, f3) || op_misaligned(f3, addr)) begin
      exc_q.push_back(addr);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      return;
    end
    t_done   = gdly + (we ? 0 : rdly);
    complete = (t_done <= TO - 1);
    last     = complete ? t_done : TO - 1;
    e.we     = we;
    e.addr   = addr - (addr % 4);
    e.wstrb  = model_wstrb(f3, addr);
    e.wdata  = model_wdata(f3, wd);
    e.len    = 8'(((gdly < TO) ? gdly : TO - 1) + 1);
    req_q.push_back(e);
    if (!we) exp_q.push_back(complete ? model_load(f3, addr, rd) : 32'd0);
    if (!complete) err_q.push_back(e.addr);
    stall_q.push_back(8'(last + 2));
    for (int t = 0; t <= last; t++) begin
      @(posedge clk); #1;
      dmem_gnt    = (t == gdly);
      dmem_rvalid = !we && (t == gdly + rdly);
      dmem_rdata  = dmem_rvalid ? rd : $urandom;
    end
    @(posedge clk); #1;  // DONE: strays and a held op must all be ignored
    dmem_gnt    = 1'($urandom_range(0, 1));
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom;
    mem_valid   = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    mem_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_valid   = 1'b0;
      dmem_gnt    = 1'($urandom_range(0, 1));
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdata  = $urandom;
      @(posedge clk); #1;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic reset_in_wait();
    req_exp_t e;
    mem_valid = 1'b1; mem_we = 1'b0; mem_funct3 = 3'd2; mem_addr = 32'h0000_0400;
    e = '{we: 1'b0, addr: 32'h0000_0400, wstrb: 4'd0, wdata: 32'd0, len: 8'd1};
    req_q.push_back(e);
    stall_q.push_back(8'd4);  // accept, REQ, two WAIT cycles (reset lands in the second)
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wait_req", {31'd0, dmem_req}, 32'd0);
    check("rst_wait_stall", {31'd0, stall}, 32'd0);
    check("rst_wait_load_data", load_data, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;  // late response from the lost access
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("rst_wait_late_rvalid", {31'd0, load_valid}, 32'd0);
  endtask

  // scoreboard monitor, sampling on the falling edge
  req_exp_t    cur;
  logic        cur_valid = 1'b0;
  int          req_run   = 0;
  int          stall_run = 0;
  logic [31:0] last_load = 32'd0;

  always @(negedge clk) begin
    if (dmem_req) begin
      if (req_run == 0) begin
        cur_valid = (req_q.size() != 0);
        if (cur_valid) cur = req_q.pop_front();
        else check("req_unexpected", {31'd0, dmem_req}, 32'd0);
      end
      req_run++;
      if (cur_valid) begin
        check("req_addr", dmem_addr, cur.addr);
        check("req_we", {31'd0, dmem_we}, {31'd0, cur.we});
        if (cur.we) begin
          check("req_wstrb", {28'd0, dmem_wstrb}, {28'd0, cur.wstrb});
          check("req_wdata", dmem_wdata, cur.wdata);
        end
      end
    end else if (req_run > 0) begin
      if (cur_valid) check("req_len", req_run, {24'd0, cur.len});
      req_run   = 0;
      cur_valid = 1'b0;
    end

    if (stall) stall_run++;
    else if (stall_run > 0) begin
      if (stall_q.size() != 0) check("stall_len", stall_run, {24'd0, stall_q.pop_front()});
      else check("stall_unexpected", stall_run, 32'd0);
      stall_run = 0;
    end

    if (mem_exc) begin
      if (exc_q.size() != 0) check("exc_addr", mem_addr, exc_q.pop_front());
      else check("exc_unexpected", {31'd0, mem_exc}, 32'd0);
    end

    if (bus_err) begin
      if (err_q.size() != 0) check("bus_err_addr", dmem_addr, err_q.pop_front());
      else check("bus_err_unexpected", {31'd0, bus_err}, 32'd0);
    end

    if (load_valid) begin
      if (exp_q.size() != 0) begin
        last_load = exp_q.pop_front();
        check("load_data", load_data, last_load);
      end else check("load_valid_unexpected", {31'd0, load_valid}, 32'd0);
    end else if (rst) last_load = 32'd0;
    else check("load_data_hold", load_data, last_load);
  end

  // main sequence
  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_funct3 = 3'd0;
    mem_addr = 32'd0; mem_wdata = 32'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("reset_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("reset_dmem_addr", dmem_addr, 32'd0);
    check("reset_dmem_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    check("reset_dmem_wdata", dmem_wdata, 32'd0);
    check("reset_load_valid", {31'd0, load_valid}, 32'd0);
    check("reset_load_data", load_data, 32'd0);
    check("reset_bus_err", {31'd0, bus_err}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    do_op(1'b0, 3'd2, 32'h100, 32'd0, 1, 1, 32'hDEAD_BEEF);
    do_op(1'b0, 3'd0, 32'h103, 32'd0, 0, 0, 32'h80FF_1234);
    do_op(1'b0, 3'd4, 32'h103, 32'd0, 0, 2, 32'h80FF_1234);
    do_op(1'b0, 3'd1, 32'h102, 32'd0, 2, 0, 32'h80FF_1234);
    do_op(1'b0, 3'd5, 32'h102, 32'd0, 1, 0, 32'h80FF_1234);
    do_op(1'b1, 3'd0, 32'h201, 32'h0000_00AB, 0, 0, 32'd0);
    do_op(1'b1, 3'd1, 32'h202, 32'h1234_CAFE, 3, 0, 32'd0);
    do_op(1'b1, 3'd2, 32'h204, 32'h0BAD_F00D, 1, 0, 32'd0);
    do_op(1'b0, 3'd2, 32'h102, 32'd0, 0, 0, 32'd0);
    do_op(1'b1, 3'd1, 32'h101, 32'd0, 0, 0, 32'd0);
    do_op(1'b0, 3'd3, 32'h100, 32'd0, 0, 0, 32'd0);
    do_op(1'b1, 3'd4, 32'h100, 32'd0, 0, 0, 32'd0);
    idle_cycles(2);

    do_op(1'b0, 3'd2, 32'h300, 32'd0, 100, 0, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    do_op(1'b1, 3'd2, 32'h304, 32'h5555_AAAA, 100, 0, 32'd0);
    do_op(1'b0, 3'd2, 32'h308, 32'd0, TO - 1, 0, 32'h0F0F_0F0F);
    do_op(1'b0, 3'd2, 32'h30C, 32'd0, TO - 1, 1, 32'h7777_7777);
    do_op(1'b1, 3'd2, 32'h310, 32'h1111_2222, TO - 1, 0, 32'd0);
    do_op(1'b0, 3'd5, 32'h312, 32'd0, TO - 2, 1, 32'h9876_5432);
    idle_cycles(1);

    reset_in_wait();
    do_op(1'b0, 3'd2, 32'h500, 32'd0, 0, 0, 32'hA5A5_5A5A);
    do_op(1'b1, 3'd2, 32'h504, 32'hC0FF_EE00, 0, 0, 32'd0);

    for (int i = 0; i < 120; i++) begin
      logic        we;
      logic [2:0]  f3;
      int          gdly;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      gdly = ($urandom_range(0, 9) == 0) ? TO + 5 : $urandom_range(0, 4);
      do_op(we, f3, 32'h1000 + $urandom_range(0, 63), $urandom, gdly,
            $urandom_range(0, 3), $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(3);
    check("left_req_q", req_q.size(), 32'd0);
    check("left_exp_q", exp_q.size(), 32'd0);
    check("left_exc_q", exc_q.size(), 32'd0);
    check("left_err_q", err_q.size(), 32'd0);
    check("left_stall_q", stall_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Load/store unit between the MEM pipeline stage and the data-memory port.
- Issues word-aligned requests with byte strobes and handles the gnt/rvalid handshake.
- Extracts and sign- or zero-extends load data, and produces the DMEM value for the writeback select (code 2'b00).
- Stalls the pipeline while an access is outstanding; flags misaligned or illegal accesses and bus timeouts.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ plus WAIT before abort; must be at least 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  the MEM stage holds a load or store op.
- mem_we  in  1  1 = store, 0 = load.
- mem_funct3  in  3  RV32I width/sign code.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  DATA_WIDTH  store data, taken from the low bits.
- stall  out  1  pipeline must hold the MEM stage and mem_* inputs stable.
- load_valid  out  1  load_data is valid this cycle.
- load_data  out  DATA_WIDTH  extended load result, routed to the writeback select.
- mem_exc  out  1  one-cycle pulse for a misaligned access or illegal funct3.
- bus_err  out  1  one-cycle pulse when an access times out.
- dmem_req  out  1  request valid.
- dmem_we  out  1  request is a write.
- dmem_addr  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2],2'b00}.
- dmem_wstrb  out  4  byte write enables.
- dmem_wdata  out  DATA_WIDTH  lane-replicated write data.
- dmem_gnt  in  1  memory accepts the request.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset: state = IDLE. All registered outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, load_valid, load_data, bus_err. The timeout counter is 0.
- Reset mid-access drops dmem_req on the next cycle. A late dmem_rvalid after reset is ignored.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
- IDLE:
  - If mem_valid is set and the op is illegal or misaligned: mem_exc=1 (combinational), stall=0, no request is issued, state stays IDLE.
  - If mem_valid is set and the op is legal: stall=1 (combinational). Register the op, set dmem_req=1 plus address, strobes and data, then go to REQ.
- REQ:
  - dmem_req stays high and all dmem_* are held until dmem_gnt.
  - On gnt for a store: go to DONE.
  - On gnt for a load: if dmem_rvalid is also high, capture the data and go to DONE; otherwise go to WAIT.
  - dmem_req drops the cycle after gnt.
- WAIT: on dmem_rvalid, capture and extend dmem_rdata, then go to DONE.
- DONE:
  - stall=0, so the pipeline advances.
  - load_valid=1 for loads only, for exactly one cycle.
  - mem_valid is ignored in DONE; the next op is accepted in the following IDLE cycle.
  - Go to IDLE.
- stall equals 1 in REQ and WAIT, and in the IDLE accept cycle.
- Store strobes and data, with o = addr[1:0]:
  - SB: wstrb = 4'b0001<<o; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011<<o; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111.
- Load extraction: byte = rdata[8*o +: 8]; half = rdata[16*o[1] +: 16].
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - load_data holds its value until the next load completes.
- Timeout:
  - The counter increments every cycle in REQ or WAIT and is cleared in IDLE.
  - When it reaches TIMEOUT_CYCLES-1 without completion: drop dmem_req, load_data=0, bus_err=1 for one cycle, go to DONE.
  - On a timed-out load, load_valid=1 with data 0.
- dmem_rvalid or dmem_gnt arriving in IDLE or DONE is ignored.

Test Plan:
- LW, addr 0x100, gnt after 2 cycles, rvalid 1 cycle later with rdata=0xDEADBEEF → stall high for 4 cycles. load_valid pulse with load_data=0xDEADBEEF. dmem_addr=0x100.
- LB addr 0x103 / LBU addr 0x103 with rdata=0x80FF_1234 → 0xFFFFFF80 / 0x00000080. LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x201, wdata=0x000000AB, immediate gnt → dmem_wstrb=4'b0010, dmem_wdata=0xABABABAB. dmem_req high for 1 cycle. Stall released in DONE. No load_valid.
- LW addr 0x102; SH addr 0x101; funct3=011 → mem_exc pulse, stall=0, dmem_req never asserted.
- Load with gnt withheld, TIMEOUT_CYCLES=16 → bus_err pulse after 16 cycles, load_data=0, returns to IDLE. A later stray rvalid is ignored.
- Reset asserted in WAIT → next cycle IDLE, dmem_req=0, stall=0. Back-to-back LW then SW issue with exactly one DONE cycle between them.
